// File: rtl/seq_output_collector_pkg.sv
// Shared types and sizing for the systolic-array sequencers (package seq_pkg).
// Lane packing order in a memory word: lane 0 occupies the LSBs.
package seq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} seq_out_state_t;

  localparam int unsigned SEQ_PE_DIM     = 3;
  localparam int unsigned SEQ_DATA_WIDTH = 16;
  localparam int unsigned MEM_WIDTH      = SEQ_DATA_WIDTH * SEQ_PE_DIM;

  function automatic int unsigned mem_width(int unsigned pe_dim, int unsigned data_width);
    return pe_dim * data_width;
  endfunction

endpackage

// File: rtl/seq_deskew_lane.sv
// One de-skew delay line: DEPTH registers of {valid, data}; DEPTH=0 is a wire.
module seq_deskew_lane #(
  parameter int unsigned DEPTH      = 0,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstb;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_shift
    logic [DEPTH-1:0]      v_q;
    logic [DATA_WIDTH-1:0] d_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rstb) begin
        v_q <= '0;
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= in_valid;
        d_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          v_q[i] <= v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
  end

endmodule

// File: rtl/seq_output_collector.sv
// Systolic-array output collector: de-skews lane results and stores aligned rows in a result memory.
// Define SEQ_OUT_ACCUM_EN to make each row a read-modify-write (lane-wise accumulate).
module seq_output_collector
  import seq_pkg::*;
#(
  parameter int unsigned PE_DIM     = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 128
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         start,
  input  logic [7:0]                   num_rows,
  input  logic [PE_DIM-1:0]            valid,
  input  logic [DATA_WIDTH-1:0]        in_data [PE_DIM],
  input  logic                         rd_en,
  input  logic [7:0]                   rd_addr,
  output logic [DATA_WIDTH*PE_DIM-1:0] rd_data,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   rows_written,
  output logic                         skew_err,
  output logic                         ovf
);

  localparam int unsigned MemW  = mem_width(PE_DIM, DATA_WIDTH);
  localparam int unsigned AddrW = $clog2(MEM_DEPTH);

  logic [PE_DIM-1:0] av;
  logic [MemW-1:0]   row;

  for (genvar k = 0; k < PE_DIM; k++) begin : g_lane
    seq_deskew_lane #(
      .DEPTH      (PE_DIM - 1 - k),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (valid[k]),
      .in_data   (in_data[k]),
      .out_valid (av[k]),
      .out_data  (row[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  seq_out_state_t   state;
  logic [7:0]       num_rows_q;
  logic [AddrW-1:0] wr_ptr;
  logic             full;
  logic             accept, commit, row_mixed, pipe_empty;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [MemW-1:0]  mem_wdata;
  logic [MemW-1:0]  mem [MEM_DEPTH];

  assign row_mixed = (|av) && !(&av);
  assign accept    = (state == S_COLLECT) && (&av) && (rows_written != num_rows_q);
  // Once the last slot is taken, wr_ptr stays put and further rows only count.
  assign commit    = accept && !full;
  assign busy      = (state != S_IDLE);

`ifdef SEQ_OUT_ACCUM_EN
  logic             acc_v;
  logic [AddrW-1:0] acc_addr;
  logic [MemW-1:0]  acc_row, acc_old, acc_sum;

  always_ff @(posedge clk) begin
    if (!rstb) acc_v <= 1'b0;
    else       acc_v <= commit;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      acc_addr <= wr_ptr;
      acc_row  <= row;
      acc_old  <= mem[wr_ptr];
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < PE_DIM; k++) begin
      acc_sum[k*DATA_WIDTH +: DATA_WIDTH] = acc_old[k*DATA_WIDTH +: DATA_WIDTH]
                                          + acc_row[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mem_we     = acc_v;
  assign mem_waddr  = acc_addr;
  assign mem_wdata  = acc_sum;
  assign pipe_empty = !acc_v;
`else
  assign mem_we     = commit;
  assign mem_waddr  = wr_ptr;
  assign mem_wdata  = row;
  assign pipe_empty = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;

  // Read-before-write: a same-address write in this cycle is not visible yet.
  always_ff @(posedge clk) begin
    if (!rstb)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr[AddrW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state        <= S_IDLE;
      num_rows_q   <= '0;
      wr_ptr       <= '0;
      full         <= 1'b0;
      rows_written <= '0;
      done         <= 1'b0;
      skew_err     <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            wr_ptr       <= '0;
            full         <= 1'b0;
            rows_written <= '0;
            skew_err     <= 1'b0;
            ovf          <= 1'b0;
            num_rows_q   <= num_rows;
            if (num_rows == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            if (rows_written != 8'hFF) rows_written <= rows_written + 8'd1;
            if (full)                                ovf    <= 1'b1;
            else if (wr_ptr == AddrW'(MEM_DEPTH - 1)) full   <= 1'b1;
            else                                      wr_ptr <= wr_ptr + 1'b1;
          end
          if (row_mixed) skew_err <= 1'b1;
          if ((rows_written == num_rows_q) && pipe_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_output_collector.sv
// Directed self-checking bench for seq_output_collector (default build and SEQ_OUT_ACCUM_EN).
module tb_seq_output_collector;

  localparam int PE = 3;
  localparam int DW = 16;
  localparam int MW = PE * DW;
  localparam int NT = 320;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    num_rows = '0;
  logic [PE-1:0] valid = '0;
  logic [DW-1:0] in_data [PE];
  logic          rd_en = 1'b0;
  logic [7:0]    rd_addr = '0;
  logic [MW-1:0] rd_data;
  logic          busy, done, skew_err, ovf;
  logic [7:0]    rows_written;

  always #5 clk = ~clk;

  seq_output_collector #(
    .PE_DIM     (PE),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (128)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .start        (start),
    .num_rows     (num_rows),
    .valid        (valid),
    .in_data      (in_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .rows_written (rows_written),
    .skew_err     (skew_err),
    .ovf          (ovf)
  );

  int total = 0;
  int bad = 0;

  bit            sv [NT][PE];
  logic [DW-1:0] sd [NT][PE];
  bit            rs [NT];
  logic [7:0]    rw_at [NT];
  bit            done_at [NT];
  bit            ovf_at [NT];
  logic [MW-1:0] rd_at [NT];
  int            done_cnt;

  typedef struct {
    logic [7:0]    addr;
    logic [MW-1:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [4];

  function automatic logic [MW-1:0] row_word(int r);
    logic [MW-1:0] w;
    for (int k = 0; k < PE; k++) w[k*DW +: DW] = {8'(r), 8'(k)};
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int t = 0; t < NT; t++) begin
      rs[t] = 1'b0;
      for (int k = 0; k < PE; k++) begin
        sv[t][k] = 1'b0;
        sd[t][k] = '0;
      end
    end
  endtask

  // Lane k of row r is 16'h{r}{k}, presented k cycles after lane 0.
  task automatic add_row(int t0, int r, int drop);
    for (int k = 0; k < PE; k++) begin
      if (k != drop) sv[t0+k][k] = 1'b1;
      sd[t0+k][k] = {8'(r), 8'(k)};
    end
  endtask

  task automatic play(int n);
    done_cnt = 0;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < PE; k++) begin
        valid[k]   = sv[t][k];
        in_data[k] = sd[t][k];
      end
      rd_en   = rs[t];
      rd_addr = 8'd0;
      @(posedge clk);
      #1;
      rw_at[t]   = rows_written;
      done_at[t] = done;
      ovf_at[t]  = ovf;
      rd_at[t]   = rd_data;
      if (done) done_cnt++;
    end
    valid = '0;
    rd_en = 1'b0;
  endtask

  task automatic do_start(int n);
    start    = 1'b1;
    num_rows = 8'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic rd(logic [7:0] addr, output logic [MW-1:0] d);
    rd_en   = 1'b1;
    rd_addr = addr;
    @(posedge clk);
    #1;
    d     = rd_data;
    rd_en = 1'b0;
  endtask

  logic [MW-1:0] d, a_val, exp_w;

  initial begin
    for (int k = 0; k < PE; k++) in_data[k] = '0;
    vecs[0] = '{addr: 8'd0, exp: 48'h0002_0001_0000};
    vecs[1] = '{addr: 8'd1, exp: 48'h0102_0101_0100};
    vecs[2] = '{addr: 8'd2, exp: 48'h0202_0201_0200};
    vecs[3] = '{addr: 8'd3, exp: 48'h0302_0301_0300};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rows", rows_written, 0);
    chk("rst_skew", skew_err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd_data", rd_data, 0);
    rstb = 1'b1;

`ifdef SEQ_OUT_ACCUM_EN
    clear_sched();
    add_row(0, 1, -1);
    do_start(1);
    play(8);
    chk("acc_done_t", done_at[4], 1);
    chk("acc_done_cnt", done_cnt, 1);
    rd(8'd0, a_val);
    clear_sched();
    add_row(0, 2, -1);
    do_start(1);
    play(8);
    chk("acc_done_cnt2", done_cnt, 1);
    rd(8'd0, d);
    for (int k = 0; k < PE; k++) begin
      exp_w[k*DW +: DW] = a_val[k*DW +: DW] + {8'd2, 8'(k)};
    end
    chk("acc_sum", d, exp_w);
`else
    // 1: spaced rows
    clear_sched();
    for (int r = 0; r < 4; r++) add_row(4 * r, r, -1);
    do_start(4);
    chk("t1_busy", busy, 1);
    play(20);
    chk("t1_before_commit", rw_at[13], 3);
    chk("t1_commit", rw_at[14], 4);
    chk("t1_done_t", done_at[15], 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_rows", rows_written, 4);
    chk("t1_idle", busy, 0);
    for (int i = 0; i < 4; i++) begin
      rd(vecs[i].addr, d);
      chk($sformatf("t1_mem%0d", i), d, vecs[i].exp);
    end

    // 2: back-to-back rows
    clear_sched();
    for (int r = 0; r < 4; r++) add_row(r, r + 4, -1);
    do_start(4);
    play(10);
    chk("t2_lat_pre", rw_at[1], 0);
    chk("t2_lat", rw_at[2], 1);
    chk("t2_row1", rw_at[3], 2);
    chk("t2_row3", rw_at[5], 4);
    chk("t2_done_t", done_at[6], 1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_skew", skew_err, 0);
    rd(8'd0, d);
    chk("t2_mem0", d, row_word(4));
    rd(8'd3, d);
    chk("t2_mem3", d, row_word(7));

    // 3: lane 1 missing on row 2
    clear_sched();
    for (int r = 0; r < 4; r++) add_row(r, r, (r == 2) ? 1 : -1);
    do_start(4);
    play(10);
    chk("t3_rows", rows_written, 3);
    chk("t3_skew", skew_err, 1);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_busy", busy, 1);
    rd(8'd2, d);
    chk("t3_mem2", d, row_word(3));
    rd(8'd3, d);
    chk("t3_mem3", d, row_word(7));
    clear_sched();
    add_row(0, 4, -1);
    play(6);
    chk("t3_done_t", done_at[3], 1);
    chk("t3_skew_sticky", skew_err, 1);
    do_start(1);
    chk("t3_skew_clr", skew_err, 0);

    // 5: same-cycle read and write of row 0
    clear_sched();
    add_row(0, 9, -1);
    rs[2] = 1'b1;
    rs[3] = 1'b1;
    play(6);
    chk("t5_old", rd_at[2], row_word(0));
    chk("t5_new", rd_at[3], row_word(9));
    chk("t5_hold", rd_at[4], row_word(9));
    chk("t5_done_t", done_at[3], 1);

    // 4: overflow past MEM_DEPTH
    clear_sched();
    for (int r = 0; r < 200; r++) add_row(r, r, -1);
    do_start(200);
    play(206);
    chk("t4_ovf_pre", ovf_at[129], 0);
    chk("t4_ovf", ovf_at[130], 1);
    chk("t4_rows130", rw_at[131], 130);
    chk("t4_rows", rows_written, 200);
    chk("t4_done_t", done_at[202], 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_ovf_sticky", ovf, 1);
    rd(8'd0, d);
    chk("t4_mem0", d, row_word(0));
    rd(8'd126, d);
    chk("t4_mem126", d, row_word(126));
    rd(8'd127, d);
    chk("t4_mem127", d, row_word(127));

    // 6: reset mid-run
    clear_sched();
    add_row(0, 1, -1);
    add_row(1, 2, -1);
    do_start(4);
    play(5);
    chk("t6_rows_pre", rows_written, 2);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rows", rows_written, 0);
    chk("t6_done", done, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_ovf", ovf, 0);
    rstb = 1'b1;
    clear_sched();
    add_row(0, 10, -1);
    do_start(1);
    play(6);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_rows_after", rows_written, 1);
    rd(8'd0, d);
    chk("t6_mem0", d, row_word(10));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
